ram_sync_dual_port: RTL
=======================

Name: ram_sync_dual_port

Overview:
- Parametrised synchronous simple-dual-port RAM: one write port and one read port, sharing clock `clk`.
- Successor to the single-port 12x32 RAM with its shared tri-state bus. Uses separate `wr_data`/`rd_data` buses, a registered read with a valid strobe, and a selectable read-during-write policy.
- Optional hardware clear of the whole array after reset, with a `busy` indication while it runs.
- Addresses that fall outside `DEPTH` are detected and flagged.
- Sits between datapath producers and consumers as local scratch or buffer storage.

Parameters:
- `DATA_W`, 12, word width in bits.
- `ADDR_W`, 5, address width in bits.
- `DEPTH`, 32, number of words. Rule: DEPTH <= 2**ADDR_W, and DEPTH need not be a power of two.
- `RDW_MODE`, 0, read-during-write to the same address: 0 = write-first (new data), 1 = read-first (old data).
- `CLEAR_ON_RESET`, 1, when 1 every word is written to 0 after reset is released.

Ports:
- `clk`  in  1  clock; all logic acts on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  write request.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `rd_en`  in  1  read request.
- `rd_addr`  in  ADDR_W  read address.
- `rd_data`  out  DATA_W  registered read data.
- `rd_valid`  out  1  one-cycle strobe; `rd_data` is valid while it is high.
- `busy`  out  1  clear sequence in progress; requests are ignored.
- `addr_err`  out  1  one-cycle strobe for an out-of-range write or read.

Behaviour:
- Reset asserted (`rst_n`=0), asynchronous, all outputs forced immediately:
  - `rd_data`=0, `rd_valid`=0, `addr_err`=0.
  - `busy`=`CLEAR_ON_RESET`.
  - FSM state = CLEAR if `CLEAR_ON_RESET`=1, otherwise READY.
  - Clear counter = 0.
  - Array contents are not reset directly.
- CLEAR state:
  - Each cycle writes 0 to address `clr_cnt`, then increments `clr_cnt`.
  - At `clr_cnt`=DEPTH-1 the FSM moves to READY on the same edge; `busy` falls on the following cycle.
  - Clear takes exactly DEPTH cycles after the first rising edge with `rst_n`=1.
  - `wr_en` and `rd_en` are ignored: no write, `rd_valid`=0, `addr_err`=0.
  - Reset asserted mid-clear restarts the clear from address 0.
- READY state, write:
  - At the edge where `wr_en`=1 and `wr_addr`<DEPTH, mem[`wr_addr`] <= `wr_data`.
- READY state, read (latency 1):
  - At the edge where `rd_en`=1: `rd_data` <= mem[`rd_addr`] and `rd_valid` <= 1.
  - `rd_valid` returns to 0 on the next edge unless `rd_en` is still 1.
  - Back-to-back reads give one result per cycle.
  - `rd_data` holds its last value while `rd_en`=0.
- Read-during-write (`wr_en`=1, `rd_en`=1, `rd_addr`==`wr_addr`, address in range):
  - `RDW_MODE`=0: `rd_data` = `wr_data` (bypass).
  - `RDW_MODE`=1: `rd_data` = the previous contents.
- Out-of-range address (address >= DEPTH):
  - Write: dropped; `addr_err`=1 for one cycle.
  - Read: `rd_data`=0 and `rd_valid`=1; `addr_err`=1 for one cycle.
  - Both ports out of range in the same cycle: a single `addr_err` pulse.
- Simultaneous in-range write and read at different addresses are independent.
- `CLEAR_ON_RESET`=0: `busy` is always 0, and contents after power-up are undefined (X in simulation).

Decomposition:
- Package `ram_pkg`:
  - Constants `RDW_WRITE_FIRST`=0 and `RDW_READ_FIRST`=1.
  - FSM state encoding: CLEAR, READY.
  - Helper function for address-in-range checking.
- Sub-module `ram_clear_ctrl`:
  - Contains the FSM and the `clr_cnt` counter.
  - Outputs `busy`, `clr_we` and `clr_addr`.
  - The top level muxes `clr_we`/`clr_addr`/0 onto the write port while `busy`=1.

Test Plan:
- Clear after reset: release `rst_n`, hold requests low. Required: `busy`=1 for exactly 32 cycles, then reads of addresses 0..31 all return 0 with `rd_valid`.
- Basic write/read: write 10 to address 2 and 20 to address 3. Required: reading 2 then 3 gives `rd_data` 10 then 20, one cycle after each `rd_en`, with `rd_valid` high on those cycles.
- Read-during-write: mem[5]=7, then in one cycle write 9 to address 5 and read address 5. Required: `rd_data`=9 when `RDW_MODE`=0, 7 when `RDW_MODE`=1; mem[5]=9 afterwards in both modes.
- Out of range with DEPTH=24, ADDR_W=5: write to address 30. Required: `addr_err` pulses and no write occurs. Then read address 30. Required: `rd_data`=0, `rd_valid`=1, `addr_err`=1.
- Reset mid-clear: assert `rst_n`=0 at clear cycle 10, release. Required: `busy` restarts and lasts a full DEPTH cycles. Requests issued during `busy` have no effect and produce no `rd_valid`.
- Streaming: `rd_en` held high over addresses 0..7 after writing values i*3. Required: `rd_valid` is continuous, and `rd_data` shows 0,3,...,21 with one-cycle lag.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants, clear-FSM encoding and address range helper for the
// simple-dual-port RAM.
package ram_pkg;

  // Read-during-write policy selectors
  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  // Clear sequencer states
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // True when addr addresses a real word; DEPTH need not be a power of two
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset clear sequencer: walks clr_cnt over 0..DEPTH-1, one word per
// cycle, and then parks in READY until the next reset.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter int DEPTH          = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam clr_state_e       RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_last;

  assign clr_last = (clr_cnt == LAST_ADDR);

  // State register; reset restarts the clear from the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= state_nxt;
  end

  // Clear address counter, advances only while clearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
  end

  // Next state: leave CLEAR on the edge that writes the last word
  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_last) state_nxt = ST_READY;
  end

  // Outputs decoded from state
  always_comb begin
    busy     = (state == ST_CLEAR);
    clr_we   = (state == ST_CLEAR);
    clr_addr = clr_cnt;
  end

endmodule

// File: rtl/ram_sync_dual_port.sv
// Simple-dual-port synchronous RAM: one write port, one registered read
// port with valid strobe, selectable read-during-write policy, optional
// hardware clear after reset and out-of-range address flagging.
module ram_sync_dual_port
  import ram_pkg::*;
#(
  parameter int DATA_W         = 12,
  parameter int ADDR_W         = 5,
  parameter int DEPTH          = 32,
  parameter int RDW_MODE       = RDW_WRITE_FIRST,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  // Internal write request after the clear/user mux
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok, rd_ok, rdw_hit, rd_go, err_now;
  wr_req_t           wreq;
  logic [DATA_W-1:0] rd_word;

  ram_clear_ctrl #(
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Address qualification; user requests are dead while clearing
  always_comb begin
    wr_ok   = addr_ok(32'(wr_addr), unsigned'(DEPTH));
    rd_ok   = addr_ok(32'(rd_addr), unsigned'(DEPTH));
    rdw_hit = wr_en && wr_ok && (wr_addr == rd_addr);
    rd_go   = rd_en && !busy;
    err_now = !busy && ((wr_en && !wr_ok) || (rd_en && !rd_ok));
  end

  // Write port mux: the clear sequencer owns the port while busy
  always_comb begin
    wreq = '0;
    if (busy) begin
      wreq.en   = clr_we;
      wreq.addr = clr_addr;
    end else begin
      wreq.en   = wr_en && wr_ok;
      wreq.addr = wr_addr;
      wreq.data = wr_data;
    end
  end

  // Storage array, no reset on contents
  always_ff @(posedge clk) begin
    if (wreq.en) mem[wreq.addr] <= wreq.data;
  end

  // Read word selection: out-of-range reads return 0; write-first bypasses
  // the incoming word, read-first simply sees the pre-edge array contents
  always_comb begin
    if (!rd_ok)                                     rd_word = '0;
    else if (RDW_MODE == RDW_WRITE_FIRST && rdw_hit) rd_word = wr_data;
    else                                            rd_word = mem[rd_addr];
  end

  // Registered read data, valid strobe and error strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      addr_err <= err_now;
      if (rd_go) rd_data <= rd_word;
    end
  end

endmodule
